// File: rtl/vga_hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module   : vga_hvsync_generator
// Purpose  : Free-running VGA raster timing generator (640x480 @ 60 Hz
//            defaults). It outputs the beam position, hsync/vsync and
//            display-enable. Define HVSYNC_STROBES_EN to add the
//            line_end/frame_end strobe outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_hvsync_generator #(
  parameter int H_DISPLAY       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_DISPLAY       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef HVSYNC_STROBES_EN
  output logic       line_end,
  output logic       frame_end,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // The 10-bit counters cannot represent a raster larger than 1024x1024.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_totals
    $error("vga_hvsync_generator: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       w_line_last;
  logic       w_frame_last;
  logic       w_hsync_act;
  logic       w_vsync_act;

  assign w_line_last  = (hpos_q == H_LAST);
  assign w_frame_last = w_line_last && (vpos_q == V_LAST);

  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (w_line_last) begin
      hpos_d = '0;
      vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Decode is purely combinational so sync/enable align with hpos/vpos.
  assign w_hsync_act = (hpos_q >= H_SYNC_FIRST) && (hpos_q <= H_SYNC_LAST);
  assign w_vsync_act = (vpos_q >= V_SYNC_FIRST) && (vpos_q <= V_SYNC_LAST);

  assign hsync      = (SYNC_ACTIVE_LOW != 0) ? ~w_hsync_act : w_hsync_act;
  assign vsync      = (SYNC_ACTIVE_LOW != 0) ? ~w_vsync_act : w_vsync_act;
  assign display_on = (hpos_q < H_VISIBLE) && (vpos_q < V_VISIBLE);
  assign hpos       = hpos_q;
  assign vpos       = vpos_q;

`ifdef HVSYNC_STROBES_EN
  assign line_end  = w_line_last;
  assign frame_end = w_frame_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_hvsync_generator
// Purpose  : Directed self-checking bench: a full-size 640x480 instance plus a
//            tiny-raster, active-high-sync instance for frame-level boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_hvsync_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       hs_b, vs_b, don_b;
  logic [9:0] hpos_b, vpos_b;
  logic       hs_s, vs_s, don_s;
  logic [9:0] hpos_s, vpos_s;
`ifdef HVSYNC_STROBES_EN
  logic       le_b, fe_b, le_s, fe_s;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int t      = 0;

  always #5 clk = ~clk;

  vga_hvsync_generator dut_big (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HVSYNC_STROBES_EN
    .line_end   (le_b),
    .frame_end  (fe_b),
`endif
    .hsync      (hs_b),
    .vsync      (vs_b),
    .display_on (don_b),
    .hpos       (hpos_b),
    .vpos       (vpos_b)
  );

  // Tiny raster: H 8+2+3+2=15 (sync 10..12), V 6+1+2+1=10 (sync 7..8).
  vga_hvsync_generator #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_LOW(0)
  ) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HVSYNC_STROBES_EN
    .line_end   (le_s),
    .frame_end  (fe_s),
`endif
    .hsync      (hs_s),
    .vsync      (vs_s),
    .display_on (don_s),
    .hpos       (hpos_s),
    .vpos       (vpos_s)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rst_n) t++;
    end
  endtask

  task automatic step_to(input int target);
    step(target - t);
  endtask

  task automatic check_big(input string tag, input int h, input int v,
                           input logic hs, input logic vs, input logic dn);
    check_val({tag, ".hpos"}, 32'(hpos_b), 32'(h));
    check_val({tag, ".vpos"}, 32'(vpos_b), 32'(v));
    check_val({tag, ".hsync"}, 32'(hs_b), 32'(hs));
    check_val({tag, ".vsync"}, 32'(vs_b), 32'(vs));
    check_val({tag, ".don"}, 32'(don_b), 32'(dn));
  endtask

  initial begin
    int h, v;

    // Reset held for three edges.
    rst_n = 1'b0;
    step(3);
    check_big("rst", 0, 0, 1'b1, 1'b1, 1'b1);
    check_val("rst.s.hpos", 32'(hpos_s), 0);
    check_val("rst.s.vpos", 32'(vpos_s), 0);
    check_val("rst.s.hsync", 32'(hs_s), 0);
    check_val("rst.s.vsync", 32'(vs_s), 0);
    check_val("rst.s.don", 32'(don_s), 1);
`ifdef HVSYNC_STROBES_EN
    check_val("rst.line_end", 32'(le_b), 0);
    check_val("rst.frame_end", 32'(fe_b), 0);
`endif

    rst_n = 1'b1;
    step(1);
    check_big("rel+1", 1, 0, 1'b1, 1'b1, 1'b1);

    // Small raster: walk a bit more than one full frame (150 clocks).
    for (int i = 0; i < 160; i++) begin
      h = t % 15;
      v = (t / 15) % 10;
      check_val("s.hpos", 32'(hpos_s), 32'(h));
      check_val("s.vpos", 32'(vpos_s), 32'(v));
      check_val("s.hsync", 32'(hs_s), 32'((h >= 10) && (h <= 12)));
      check_val("s.vsync", 32'(vs_s), 32'((v >= 7) && (v <= 8)));
      check_val("s.don", 32'(don_s), 32'((h < 8) && (v < 6)));
`ifdef HVSYNC_STROBES_EN
      check_val("s.line_end", 32'(le_s), 32'(h == 14));
      check_val("s.frame_end", 32'(fe_s), 32'((h == 14) && (v == 9)));
`endif
      step(1);
    end

    // Full-size raster: horizontal boundaries on line 0.
    step_to(639); check_big("h639", 639, 0, 1'b1, 1'b1, 1'b1);
    step_to(640); check_big("h640", 640, 0, 1'b1, 1'b1, 1'b0);
    step_to(655); check_big("h655", 655, 0, 1'b1, 1'b1, 1'b0);
    step_to(656); check_big("h656", 656, 0, 1'b0, 1'b1, 1'b0);
    step_to(751); check_big("h751", 751, 0, 1'b0, 1'b1, 1'b0);
    step_to(752); check_big("h752", 752, 0, 1'b1, 1'b1, 1'b0);
`ifdef HVSYNC_STROBES_EN
    step_to(798); check_val("b.line_end798", 32'(le_b), 0);
`endif
    step_to(799); check_big("h799", 799, 0, 1'b1, 1'b1, 1'b0);
`ifdef HVSYNC_STROBES_EN
    check_val("b.line_end799", 32'(le_b), 1);
    check_val("b.frame_end799", 32'(fe_b), 0);
`endif
    step_to(800);  check_big("wrap", 0, 1, 1'b1, 1'b1, 1'b1);
    step_to(1439); check_big("l1h639", 639, 1, 1'b1, 1'b1, 1'b1);
    step_to(1440); check_big("l1h640", 640, 1, 1'b1, 1'b1, 1'b0);

    // Mid-line, mid-sync reset.
    step_to(1500); check_big("pre_rst", 700, 1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1);
    check_big("midrst", 0, 0, 1'b1, 1'b1, 1'b1);
    check_val("midrst.s.hpos", 32'(hpos_s), 0);
    check_val("midrst.s.vpos", 32'(vpos_s), 0);
    rst_n = 1'b1;
    t = 0;
    step(1); check_big("resume1", 1, 0, 1'b1, 1'b1, 1'b1);
    step(5); check_big("resume6", 6, 0, 1'b1, 1'b1, 1'b1);
    check_val("resume.s.hpos", 32'(hpos_s), 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_hvsync_generator.md
Name: vga_hvsync_generator

Overview:
Free-running VGA raster timing generator for 640x480 at 60 Hz, one pixel per clock (25.175 MHz nominal; a 24–25 MHz clock is acceptable).
- Outputs beam position counters, horizontal/vertical sync and a display-enable.
- Downstream pixel logic derives RGB from these outputs.
- The top level drives the TinyVGA PMOD pins from hsync/vsync.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while asserted; 0 = sync pulses drive 1

Ports:
clk  input  1  pixel clock; all state updates on its rising edge
rst_n  input  1  synchronous active-low reset
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
display_on  output  1  high while the beam is in the visible area
hpos  output  10  current pixel column, 0..H_TOTAL-1
vpos  output  10  current line, 0..V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
  - Both totals must be ≤ 1024.
- Reset: if rst_n is low at a rising clk edge, hpos←0 and vpos←0. This applies at any point in a frame, including mid-line or mid-sync.
  - With defaults, outputs in reset are: hsync=1, vsync=1, display_on=1.
- Counting:
  - Each non-reset clock, hpos increments by 1.
  - When hpos == H_TOTAL-1: hpos wraps to 0 and vpos advances on the same edge.
  - vpos advances by 1, or wraps to 0 when vpos == V_TOTAL-1.
  - A full frame is H_TOTAL×V_TOTAL = 420000 clocks.
- Decode: hsync, vsync and display_on are pure combinational functions of the registered hpos/vpos. There is zero latency relative to hpos/vpos.
- hsync:
  - Asserted when H_DISPLAY+H_FRONT ≤ hpos ≤ H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - Output level is 0 when asserted if SYNC_ACTIVE_LOW=1, else 1.
- vsync:
  - Asserted when V_DISPLAY+V_FRONT ≤ vpos ≤ V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), for the whole line.
  - Same polarity rule as hsync.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- hpos/vpos never hold a value ≥ H_TOTAL/V_TOTAL. No enable input; the generator never stalls.

Optional Feature:
Macro HVSYNC_STROBES_EN.
- When defined, two extra 1-bit outputs are added:
  - line_end: high for exactly the one cycle where hpos == H_TOTAL-1.
  - frame_end: high for exactly the one cycle where hpos == H_TOTAL-1 and vpos == V_TOTAL-1.
  - Both are combinational from the counters and are 0 during the reset cycle only if the counters are not at those values (i.e. 0 after reset).
- When not defined, these ports do not exist; all other behaviour is identical.

Test Plan:
- Assert rst_n=0 for 3 clocks, then release -> hpos=0, vpos=0, hsync=1, vsync=1, display_on=1; hpos=1 one clock after release.
- Count 640 clocks from reset -> hpos=640, display_on falls to 0 exactly then. hsync=1 at hpos 655, 0 at hpos 656..751, 1 again at 752.
- Run 799 clocks -> hpos=799, vpos=0; next clock -> hpos=0, vpos=1. display_on returns to 1 at hpos=0 of lines 1..479 and stays 0 for vpos 480..524.
- Run 490×800 clocks -> vpos=490, vsync=0 for all of lines 490 and 491, vsync=1 at vpos=492. At 420000 clocks -> hpos=0, vpos=0 (frame wrap).
- Mid-frame reset: at hpos=700, vpos=300, pull rst_n low for 1 clock -> next edge hpos=0, vpos=0; counting resumes normally.
- With HVSYNC_STROBES_EN and SYNC_ACTIVE_LOW=0: line_end pulses once per 800 clocks at hpos=799; frame_end pulses once per 420000 clocks; hsync reads 1 only during hpos 656..751.
